// File: rtl/delta_pkg.sv
// -----------------------------------------------------------------------------
// delta_pkg
// Shared types and constants for the delta event packer.
//   - evt_entry_t : one queued change event (channel, value, optional timestamp)
//   - state_t     : packet FSM state encoding
//   - header tag / format-bit constants and the header builder function
// Optional build macro: DELTA_PACKER_TIMESTAMP_EN (adds ts field and ST_TS).
// -----------------------------------------------------------------------------
package delta_pkg;

  localparam int         NUM_CH          = 4;
  localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;
  localparam logic [1:0] HDR_FMT_BASIC   = 2'b00;  // 2-byte packet: HDR, DATA
  localparam logic [1:0] HDR_FMT_TS      = 2'b01;  // 3-byte packet: HDR, DATA, TS
  localparam logic [3:0] DROP_CNT_MAX    = 4'hF;

  typedef struct packed {
`ifdef DELTA_PACKER_TIMESTAMP_EN
    logic [7:0] ts;
`endif
    logic [1:0] ch;
    logic [7:0] data;
  } evt_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
`ifdef DELTA_PACKER_TIMESTAMP_EN
    ST_TS   = 2'b11,
`endif
    ST_DATA = 2'b10
  } state_t;

  // Header byte layout: {tag nibble, format bits, channel index}
  function automatic logic [7:0] make_header(input logic [3:0] tag,
                                             input logic [1:0] fmt,
                                             input logic [1:0] ch);
    return {tag, fmt, ch};
  endfunction

endpackage

// File: rtl/delta_event_packer_if.sv
// -----------------------------------------------------------------------------
// delta_event_packer_if
// Event input and byte-stream output of the packer bundled as one interface.
//   evt_valid/evt_ch/evt_data : change event from the detector (single-cycle)
//   out_data/out_valid        : packet byte toward the consumer
//   out_ready                 : consumer accepts the byte
// Modports: master = environment (detector + consumer), slave = packer.
// -----------------------------------------------------------------------------
interface delta_event_packer_if;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic [7:0] evt_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output evt_valid, evt_ch, evt_data, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  evt_valid, evt_ch, evt_data, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/delta_evt_fifo.sv
// -----------------------------------------------------------------------------
// delta_evt_fifo
// Event FIFO with combinational head read and drop accounting.
//   clk, rst_n   : clock, async active-low reset
//   push_i       : event offered this cycle
//   entry_i      : event contents
//   pop_i        : remove head entry (only issued when non-empty)
//   clear_ovf_i  : clear sticky overflow and drop counter
//   head_o       : current head entry (valid when count_o != 0)
//   count_o      : occupied entries
//   empty_o      : no entries
//   ovf_o        : sticky, an event was dropped
//   drop_cnt_o   : saturating dropped-event count
// -----------------------------------------------------------------------------
module delta_evt_fifo
  import delta_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  evt_entry_t               entry_i,
  input  logic                     pop_i,
  input  logic                     clear_ovf_i,
  output evt_entry_t               head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic [3:0]               drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  evt_entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [3:0]             drop_q, drop_d;
  logic                   full_s;
  logic                   accept_s;
  logic                   drop_s;

  assign full_s   = (count_q == FULL_CNT);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign accept_s = push_i & (~full_s | pop_i);
  assign drop_s   = push_i & full_s & ~pop_i;

  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == CNT_W'(0));
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_q;

  // Next-state for pointers, occupancy and drop accounting
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({accept_s, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop coinciding with a clear wins and restarts the count at 1.
    if (drop_s) begin
      ovf_d = 1'b1;
      if (clear_ovf_i) begin
        drop_d = 4'd1;
      end else if (drop_q != DROP_CNT_MAX) begin
        drop_d = drop_q + 4'd1;
      end else begin
        drop_d = drop_q;
      end
    end else if (clear_ovf_i) begin
      ovf_d  = 1'b0;
      drop_d = 4'd0;
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are only read while occupied, so no reset
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/delta_event_packer.sv
// -----------------------------------------------------------------------------
// delta_event_packer
// Queues change events and drains them as byte packets over valid/ready.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : evt_valid/evt_ch/evt_data in, out_data/out_valid/out_ready
//   fifo_count_o   : occupied FIFO entries
//   ovf_o          : sticky, at least one event dropped
//   drop_cnt_o     : saturating dropped-event count (0..15)
//   clear_ovf_i    : clear ovf_o and drop_cnt_o on the next edge
// Packet: header {HDR_TAG, fmt, ch} then data byte.
// Optional build macro DELTA_PACKER_TIMESTAMP_EN: adds an 8-bit free-running
// timestamp captured at push and sent as a third byte; header fmt = 2'b01.
// -----------------------------------------------------------------------------
module delta_event_packer
  import delta_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter logic [3:0] HDR_TAG = HDR_TAG_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  delta_event_packer_if.slave     bus,
  output logic [$clog2(DEPTH):0]  fifo_count_o,
  output logic                    ovf_o,
  output logic [3:0]              drop_cnt_o,
  input  logic                    clear_ovf_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef DELTA_PACKER_TIMESTAMP_EN
  localparam logic [1:0] HDR_FMT = HDR_FMT_TS;
`else
  localparam logic [1:0] HDR_FMT = HDR_FMT_BASIC;
`endif

  state_t      state_q, state_d;
  evt_entry_t  entry_s;
  evt_entry_t  head_s;
  logic        empty_s;
  logic        pop_s;
  logic        remain_s;

`ifdef DELTA_PACKER_TIMESTAMP_EN
  logic [7:0]  ts_q;

  // Free-running timestamp, wraps 255 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= 8'd0;
    end else begin
      ts_q <= ts_q + 8'd1;
    end
  end

  assign entry_s = '{ts: ts_q, ch: bus.evt_ch, data: bus.evt_data};
`else
  assign entry_s = '{ch: bus.evt_ch, data: bus.evt_data};
`endif

  delta_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (bus.evt_valid),
    .entry_i     (entry_s),
    .pop_i       (pop_s),
    .clear_ovf_i (clear_ovf_i),
    .head_o      (head_s),
    .count_o     (fifo_count_o),
    .empty_o     (empty_s),
    .ovf_o       (ovf_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  // Entries left after popping the head: at count 1 the FIFO is never full,
  // so a simultaneous event is always accepted and keeps the stream going.
  assign remain_s = (fifo_count_o > CNT_W'(1)) | bus.evt_valid;

  // Packet FSM next-state and byte output decode
  always_comb begin
    state_d       = state_q;
    pop_s         = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = make_header(HDR_TAG, HDR_FMT, head_s.ch);
        if (bus.out_ready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        bus.out_valid = 1'b1;
        bus.out_data  = head_s.data;
        if (bus.out_ready) begin
`ifdef DELTA_PACKER_TIMESTAMP_EN
          state_d = ST_TS;
`else
          pop_s   = 1'b1;
          state_d = remain_s ? ST_HDR : ST_IDLE;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef DELTA_PACKER_TIMESTAMP_EN
      ST_TS: begin
        bus.out_valid = 1'b1;
        bus.out_data  = head_s.ts;
        if (bus.out_ready) begin
          pop_s   = 1'b1;
          state_d = remain_s ? ST_HDR : ST_IDLE;
        end else begin
          state_d = ST_TS;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_delta_event_packer.sv
module tb_delta_event_packer;

  logic       clk;
  logic       rst_n;
  logic [2:0] fifo_count;
  logic       ovf;
  logic [3:0] drop_cnt;
  logic       clear_ovf;
  int         checks;
  int         errors;
  logic [7:0] exp_h [4];
  logic [7:0] exp_d [4];

  delta_event_packer_if bus ();

  delta_event_packer #(.DEPTH(4), .HDR_TAG(4'hA)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .fifo_count_o (fifo_count),
    .ovf_o        (ovf),
    .drop_cnt_o   (drop_cnt),
    .clear_ovf_i  (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DELTA_PACKER_TIMESTAMP_EN
  localparam logic [7:0] FMT = 8'h04;
`else
  localparam logic [7:0] FMT = 8'h00;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume the trailing timestamp byte when that format is built
  task automatic skip_ts();
`ifdef DELTA_PACKER_TIMESTAMP_EN
    step();
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    clear_ovf = 1'b0;
    bus.evt_valid = 1'b0;
    bus.evt_ch = 2'd0;
    bus.evt_data = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_data", 16'(bus.out_data), 16'h00);
    chk("rst_count", 16'(fifo_count), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    chk("rst_drop", 16'(drop_cnt), 16'd0);
    rst_n = 1'b1;
    step();

    // Single event, consumer always ready
    bus.out_ready = 1'b1;
    bus.evt_valid = 1'b1; bus.evt_ch = 2'd2; bus.evt_data = 8'h5C;
    step();
    bus.evt_valid = 1'b0;
    chk("single_cnt1", 16'(fifo_count), 16'd1);
    chk("single_idle", 16'(bus.out_valid), 16'd0);
    step();
    chk("single_hdr_v", 16'(bus.out_valid), 16'd1);
    chk("single_hdr", 16'(bus.out_data), 16'(8'hA2 | FMT));
    step();
    chk("single_data", 16'(bus.out_data), 16'h5C);
    skip_ts();
    step();
    chk("single_done_v", 16'(bus.out_valid), 16'd0);
    chk("single_done_cnt", 16'(fifo_count), 16'd0);

    // Back-pressure on the header
    bus.out_ready = 1'b0;
    bus.evt_valid = 1'b1; bus.evt_ch = 2'd1; bus.evt_data = 8'h33;
    step();
    bus.evt_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_v", 16'(bus.out_valid), 16'd1);
      chk("bp_hold_d", 16'(bus.out_data), 16'(8'hA1 | FMT));
    end
    bus.out_ready = 1'b1;
    chk("bp_hdr", 16'(bus.out_data), 16'(8'hA1 | FMT));
    step();
    chk("bp_data_v", 16'(bus.out_valid), 16'd1);
    chk("bp_data", 16'(bus.out_data), 16'h33);
    skip_ts();
    step();
    chk("bp_done_v", 16'(bus.out_valid), 16'd0);

    // Overflow: 6 events into a 4-deep FIFO, nothing drained
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.evt_valid = 1'b1;
      bus.evt_ch = 2'(i);
      bus.evt_data = 8'h10 + 8'(i);
      step();
    end
    bus.evt_valid = 1'b0;
    chk("ovf_cnt", 16'(fifo_count), 16'd4);
    chk("ovf_flag", 16'(ovf), 16'd1);
    chk("ovf_drop2", 16'(drop_cnt), 16'd2);
    chk("ovf_head", 16'(bus.out_data), 16'(8'hA0 | FMT));
    // 14 more drops saturate the counter at 15
    bus.evt_valid = 1'b1; bus.evt_ch = 2'd3; bus.evt_data = 8'hFF;
    repeat (14) step();
    bus.evt_valid = 1'b0;
    chk("ovf_drop_sat", 16'(drop_cnt), 16'd15);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_hdr", 16'(bus.out_data), 16'(8'hA0 | FMT | 8'(i)));
      step();
      chk("ovf_drain_data", 16'(bus.out_data), 16'(8'h10 + 8'(i)));
      step();
      skip_ts();
    end
    chk("ovf_drain_v", 16'(bus.out_valid), 16'd0);
    chk("ovf_drain_cnt", 16'(fifo_count), 16'd0);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("clr_ovf", 16'(ovf), 16'd0);
    chk("clr_drop", 16'(drop_cnt), 16'd0);

    // Full FIFO with push on the popping cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.evt_valid = 1'b1;
      bus.evt_ch = 2'(i);
      bus.evt_data = 8'h40 + 8'(i);
      step();
    end
    bus.evt_valid = 1'b0;
    step();
    chk("full_cnt", 16'(fifo_count), 16'd4);
    chk("full_hdr", 16'(bus.out_data), 16'(8'hA0 | FMT));
    bus.out_ready = 1'b1;
    step();
    chk("full_data", 16'(bus.out_data), 16'h40);
    skip_ts();
    bus.evt_valid = 1'b1; bus.evt_ch = 2'd1; bus.evt_data = 8'hEE;
    step();
    bus.evt_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("fpop_cnt", 16'(fifo_count), 16'd4);
    chk("fpop_drop", 16'(drop_cnt), 16'd0);
    chk("fpop_ovf", 16'(ovf), 16'd0);
    chk("fpop_hdr", 16'(bus.out_data), 16'(8'hA1 | FMT));
    // Clear and drop in the same cycle: the drop wins
    bus.evt_valid = 1'b1; bus.evt_ch = 2'd0; bus.evt_data = 8'h99;
    clear_ovf = 1'b1;
    step();
    bus.evt_valid = 1'b0;
    clear_ovf = 1'b0;
    chk("clrdrop_ovf", 16'(ovf), 16'd1);
    chk("clrdrop_cnt", 16'(drop_cnt), 16'd1);
    chk("clrdrop_fifo", 16'(fifo_count), 16'd4);
    exp_h[0] = 8'hA1 | FMT; exp_d[0] = 8'h41;
    exp_h[1] = 8'hA2 | FMT; exp_d[1] = 8'h42;
    exp_h[2] = 8'hA3 | FMT; exp_d[2] = 8'h43;
    exp_h[3] = 8'hA1 | FMT; exp_d[3] = 8'hEE;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fpop_drain_hdr", 16'(bus.out_data), 16'(exp_h[i]));
      step();
      chk("fpop_drain_data", 16'(bus.out_data), 16'(exp_d[i]));
      step();
      skip_ts();
    end
    chk("fpop_drain_v", 16'(bus.out_valid), 16'd0);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;

    // Reset after the header has been accepted
    bus.evt_valid = 1'b1; bus.evt_ch = 2'd3; bus.evt_data = 8'h77;
    step();
    bus.evt_valid = 1'b0;
    step();
    chk("mid_hdr", 16'(bus.out_data), 16'(8'hA3 | FMT));
    step();
    chk("mid_data", 16'(bus.out_data), 16'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 16'(bus.out_valid), 16'd0);
    chk("mid_rst_cnt", 16'(fifo_count), 16'd0);
    chk("mid_rst_d", 16'(bus.out_data), 16'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_after_v", 16'(bus.out_valid), 16'd0);
    end

`ifdef DELTA_PACKER_TIMESTAMP_EN
    // Timestamp counter has advanced 3 edges since reset release
    repeat (4) step();
    bus.evt_valid = 1'b1; bus.evt_ch = 2'd3; bus.evt_data = 8'hF0;
    step();
    bus.evt_valid = 1'b0;
    step();
    chk("ts_hdr", 16'(bus.out_data), 16'hA7);
    step();
    chk("ts_data", 16'(bus.out_data), 16'hF0);
    step();
    chk("ts_ts", 16'(bus.out_data), 16'h07);
    step();
    chk("ts_done_v", 16'(bus.out_valid), 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delta_event_packer.md
Name: delta_event_packer

Overview:
- Downstream of the 4-channel deadband change detector.
- Captures each change event (channel index plus new 8-bit value) into a small FIFO.
- Drains events as byte packets over a valid/ready byte interface, toward the serial/pin output stage.
- Decouples bursty detector events from a slower consumer, and reports dropped events.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- HDR_TAG, 4'hA, upper nibble of every header byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- evt_valid  in  1  single-cycle change pulse from the detector
- evt_ch  in  2  channel index of the event
- evt_data  in  8  new stored value of the event
- out_data  out  8  packet byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte
- fifo_count  out  log2(DEPTH)+1  occupied entries
- ovf  out  1  sticky: at least one event dropped
- drop_cnt  out  4  saturating count of dropped events
- clear_ovf  in  1  synchronous clear of ovf and drop_cnt

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; FSM to IDLE.
  - out_valid=0, out_data=0, fifo_count=0, ovf=0, drop_cnt=0.
  - A partially sent packet is abandoned with no resume.
- Push: on a clk edge with evt_valid=1 and FIFO not full, {evt_ch, evt_data} is written at the write pointer; fifo_count increments.
- Full drop: with evt_valid=1 and FIFO full (no pop in the same cycle), the event is discarded, ovf is set, and drop_cnt increments, saturating at 15.
- Push and pop in the same cycle: both take effect and fifo_count is unchanged. When full, a push coinciding with a pop is accepted, not dropped.
- Pop: occurs only when the last byte of a packet is accepted (out_valid & out_ready).
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH; full/empty are derived from fifo_count.
- FSM states: IDLE, HDR, DATA (plus TS with the optional feature).
  - IDLE: out_valid=0. If fifo_count≠0, go to HDR next edge.
  - HDR: out_valid=1, out_data={HDR_TAG, 2'b00, head.ch}. On out_ready, go to DATA.
  - DATA: out_valid=1, out_data=head.data. On out_ready, pop. Then go to HDR if entries remain after the pop, else IDLE.
- Handshake rules:
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
  - out_ready is ignored in IDLE.
- Latency from idle: evt_valid sampled at edge N gives fifo_count=1 after edge N, HDR after edge N+1. Header presented N+1..; back-to-back packets need no idle cycle.
- clear_ovf clears ovf and drop_cnt on the next edge. A drop in the same cycle wins: ovf=1, drop_cnt=1.
- The head entry is read combinationally from the storage array; no read latency.

Optional Feature:
- Macro: DELTA_PACKER_TIMESTAMP_EN.
- When defined:
  - A free-running 8-bit timestamp counter (reset 0, wraps 255→0) is stored with each entry at push.
  - The FSM adds state TS after DATA. TS presents the stored timestamp, and the pop happens on TS acceptance instead of DATA.
  - Packets are 3 bytes.
  - The header is {HDR_TAG, 2'b01, ch} so the consumer can tell the formats apart.
- When undefined: no counter and no TS state; 2-byte packets; header bits [3:2]=2'b00.

Decomposition:
- Shared package delta_pkg holds:
  - the event entry struct (ch[1:0], data[7:0], optional ts[7:0]);
  - the FSM state enum;
  - HDR_TAG default and header format-bit constants;
  - NUM_CH=4.
- One natural sub-module, delta_evt_fifo: storage, pointers, count, full/empty, drop accounting.
- The packet FSM stays in the top.

Test Plan:
- Single event: ch=2, data=8'h5C, out_ready=1 → bytes 8'hA2, 8'h5C on consecutive cycles; fifo_count returns to 0; out_valid low after.
- Back-pressure: event ch=1, data=8'h33, out_ready=0 for 5 cycles → out_data holds 8'hA1 with out_valid=1 throughout; then 8'hA1, 8'h33 with no gaps once ready.
- Overflow: out_ready=0, 6 events → fifo_count=4, ovf=1, drop_cnt=2. Drain yields the first 4 events in order. clear_ovf → ovf=0, drop_cnt=0.
- Full plus simultaneous pop: FIFO full, evt_valid on the DATA-accept cycle → event accepted, drop_cnt unchanged, fifo_count stays 4.
- Reset mid-packet: assert rst_n=0 after the header is accepted → out_valid=0 immediately (async), fifo_count=0; no DATA byte after release.
- DELTA_PACKER_TIMESTAMP_EN: event at timestamp 8'h07, ch=3, data=8'hF0 → bytes 8'hA7, 8'hF0, 8'h07.
